// File: rtl/wb_result_queue.sv
// wb_result_queue: in-order writeback queue between execute/memory and the
// register file. Execute pushes every register-writing instruction. ALU
// results enter ready, and loads become ready when memory responds. Results
// retire strictly in program order onto the registered writeback/forward bus.
// Decode is stalled while a source register still has an unretired write.

module wb_result_queue #(
    parameter int DEPTH = 4,   // power of two, >= 2
    parameter int DBITS = 32,
    parameter int RBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // execute push
    input  logic             ex_valid,
    input  logic             ex_load,
    input  logic [RBITS-1:0] ex_rd,
    input  logic [DBITS-1:0] ex_result,
    // memory response, in load-issue order
    input  logic             mem_valid,
    input  logic [DBITS-1:0] mem_data,
    // decode hazard check
    input  logic [RBITS-1:0] rs0,
    input  logic [RBITS-1:0] rs1,
    output logic             stall,
    output logic             full,
    // writeback / forward bus
    output logic             wb_en,
    output logic [RBITS-1:0] regIndexWr,
    output logic [DBITS-1:0] regFw,
    output logic             err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Per-entry state: valid/ready carry the queue semantics, rd/data are payload.
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_ready;
    logic [RBITS-1:0] r_rd   [DEPTH];
    logic [DBITS-1:0] r_data [DEPTH];

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             r_wb_en;
    logic [RBITS-1:0] r_reg_index_wr;
    logic [DBITS-1:0] r_reg_fw;
    logic             r_err;

    logic             w_full;
    logic             w_push;
    logic             w_retire;
    logic [DEPTH-1:0] w_pending;
    logic             w_fill_hit;
    logic [PW-1:0]    w_fill_idx;
    logic [PW-1:0]    w_scan_idx;
    logic             w_fill;
    logic             w_stall;

    // Full is judged on the current count, so a same-cycle pop never frees a slot.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = ex_valid && !w_full;
    // Head must already be ready at the start of the cycle; a fill landing on
    // the head this cycle retires on the next edge.
    assign w_retire  = r_valid[r_head] && r_ready[r_head];
    assign w_pending = r_valid & ~r_ready;
    assign w_fill    = mem_valid && w_fill_hit;

    // Find the oldest load still waiting for data, scanning outward from head.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_fill_hit = 1'b0;
        w_fill_idx = '0;
        w_scan_idx = '0;
        // Scan youngest-to-oldest so the last hit, i.e. the oldest, wins.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_scan_idx = r_head + PW'(i);
            if (w_pending[w_scan_idx]) begin
                w_fill_hit = 1'b1;
                w_fill_idx = w_scan_idx;
            end
        end
    end

    // Hazard: any in-flight writer of rs0/rs1, including the one retiring now
    // and the one being pushed this cycle.
    always_comb begin
        w_stall = ex_valid && ((ex_rd == rs0) || (ex_rd == rs1));
        for (int j = 0; j < DEPTH; j++) begin
            if (r_valid[j] && ((r_rd[j] == rs0) || (r_rd[j] == rs1))) begin
                w_stall = 1'b1;
            end
        end
    end

    // Queue control, writeback bus and error flag.
    // Push (tail, invalid slot), fill (valid, not-ready slot) and retire (head,
    // ready slot) can never target the same entry, so all three may coexist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid        <= '0;
            r_ready        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_wb_en        <= 1'b0;
            r_reg_index_wr <= '0;
            r_reg_fw       <= '0;
            r_err          <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_ready[r_tail] <= !ex_load;
                r_tail          <= r_tail + 1'b1;
            end

            if (w_fill) begin
                r_ready[w_fill_idx] <= 1'b1;
            end

            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end

            case ({w_push, w_retire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // The bus holds its last retirement so it always mirrors the
            // register file; only wb_en drops.
            if (w_retire) begin
                r_wb_en        <= 1'b1;
                r_reg_index_wr <= r_rd[r_head];
                r_reg_fw       <= r_data[r_head];
            end else begin
                r_wb_en        <= 1'b0;
            end

            if ((ex_valid && w_full) || (mem_valid && !w_fill_hit)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entry payload. Loads also capture ex_result; it is overwritten by the fill.
    // NOTE: payload storage has no reset; valid/ready gate every use, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= ex_rd;
            r_data[r_tail] <= ex_result;
        end
        if (w_fill) begin
            r_data[w_fill_idx] <= mem_data;
        end
    end

    assign stall      = w_stall;
    assign full       = w_full;
    assign wb_en      = r_wb_en;
    assign regIndexWr = r_reg_index_wr;
    assign regFw      = r_reg_fw;
    assign err        = r_err;

endmodule

// File: tb/tb_wb_result_queue.sv
// Testbench for wb_result_queue: table of per-cycle vectors plus hand-written
// sequences for full/overflow, back-to-back wrap and mid-stream reset.

module tb_wb_result_queue;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_load;
    logic [3:0]  ex_rd;
    logic [31:0] ex_result;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic [3:0]  rs0;
    logic [3:0]  rs1;
    logic        stall;
    logic        full;
    logic        wb_en;
    logic [3:0]  regIndexWr;
    logic [31:0] regFw;
    logic        err;

    int n_cmp;
    int n_fail;

    wb_result_queue #(.DEPTH(4), .DBITS(32), .RBITS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_load    (ex_load),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .rs0        (rs0),
        .rs1        (rs1),
        .stall      (stall),
        .full       (full),
        .wb_en      (wb_en),
        .regIndexWr (regIndexWr),
        .regFw      (regFw),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock of stimulus: stall/full expected before the edge,
    // bus and err expected after it.
    typedef struct {
        logic        ev;
        logic        ld;
        logic [3:0]  rd;
        logic [31:0] res;
        logic        mv;
        logic [31:0] md;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic        x_stall;
        logic        x_full;
        logic        x_wb;
        logic [3:0]  x_idx;
        logic [31:0] x_fw;
        logic        x_err;
    } vec_t;

    function automatic vec_t mk(logic ev, logic ld, logic [3:0] rd, logic [31:0] res,
                                logic mv, logic [31:0] md, logic [3:0] s0, logic [3:0] s1,
                                logic xs, logic xf, logic xw, logic [3:0] xi,
                                logic [31:0] xd, logic xe);
        vec_t v;
        v.ev = ev; v.ld = ld; v.rd = rd; v.res = res;
        v.mv = mv; v.md = md; v.s0 = s0; v.s1 = s1;
        v.x_stall = xs; v.x_full = xf; v.x_wb = xw;
        v.x_idx = xi; v.x_fw = xd; v.x_err = xe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        ex_valid  = v.ev;
        ex_load   = v.ld;
        ex_rd     = v.rd;
        ex_result = v.res;
        mem_valid = v.mv;
        mem_data  = v.md;
        rs0       = v.s0;
        rs1       = v.s1;
        #1;
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, v.x_stall});
        check({tag, ".full"},  {31'd0, full},  {31'd0, v.x_full});
        @(posedge clk);
        #1;
        check({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, v.x_wb});
        check({tag, ".idx"},   {28'd0, regIndexWr}, {28'd0, v.x_idx});
        check({tag, ".fw"},    regFw, v.x_fw);
        check({tag, ".err"},   {31'd0, err}, {31'd0, v.x_err});
    endtask

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n     = 1'b0;
        ex_valid  = 1'b0;
        ex_load   = 1'b0;
        ex_rd     = 4'd0;
        ex_result = 32'd0;
        mem_valid = 1'b0;
        mem_data  = 32'd0;
        rs0       = 4'd15;
        rs1       = 4'd15;

        //           ev ld rd  res           mv md            s0 s1   stl full wb idx fw          err
        // ALU r3=0x11: retires two cycles after being presented
        tbl[0]  = mk(1, 0, 3,  32'h11,       0, 32'h0,        3, 15,  1, 0, 0, 0, 32'h0,        0);
        tbl[1]  = mk(0, 0, 0,  32'h0,        0, 32'h0,        3, 15,  1, 0, 1, 3, 32'h11,       0);
        tbl[2]  = mk(0, 0, 0,  32'h0,        0, 32'h0,        3, 15,  0, 0, 0, 3, 32'h11,       0);
        // load r5, ALU r6, ALU r7; ALUs wait behind the load
        tbl[3]  = mk(1, 1, 5,  32'h0,        0, 32'h0,       15, 15,  0, 0, 0, 3, 32'h11,       0);
        tbl[4]  = mk(1, 0, 6,  32'h22,       0, 32'h0,       15,  5,  1, 0, 0, 3, 32'h11,       0);
        tbl[5]  = mk(1, 0, 7,  32'h33,       0, 32'h0,        6, 15,  1, 0, 0, 3, 32'h11,       0);
        tbl[6]  = mk(0, 0, 0,  32'h0,        0, 32'h0,        7, 15,  1, 0, 0, 3, 32'h11,       0);
        tbl[7]  = mk(0, 0, 0,  32'h0,        0, 32'h0,       15, 15,  0, 0, 0, 3, 32'h11,       0);
        tbl[8]  = mk(0, 0, 0,  32'h0,        1, 32'hAA,      15, 15,  0, 0, 0, 3, 32'h11,       0);
        tbl[9]  = mk(0, 0, 0,  32'h0,        0, 32'h0,       15, 15,  0, 0, 1, 5, 32'hAA,       0);
        tbl[10] = mk(0, 0, 0,  32'h0,        0, 32'h0,       15, 15,  0, 0, 1, 6, 32'h22,       0);
        tbl[11] = mk(0, 0, 0,  32'h0,        0, 32'h0,       15, 15,  0, 0, 1, 7, 32'h33,       0);
        tbl[12] = mk(0, 0, 0,  32'h0,        0, 32'h0,       15, 15,  0, 0, 0, 7, 32'h33,       0);
        // loads r8, r9; fill r8; then push + retire + fill in one cycle
        tbl[13] = mk(1, 1, 8,  32'h0,        0, 32'h0,       15, 15,  0, 0, 0, 7, 32'h33,       0);
        tbl[14] = mk(1, 1, 9,  32'h0,        0, 32'h0,        8, 15,  1, 0, 0, 7, 32'h33,       0);
        tbl[15] = mk(0, 0, 0,  32'h0,        1, 32'h88,      15, 15,  0, 0, 0, 7, 32'h33,       0);
        tbl[16] = mk(1, 0, 2,  32'h99,       1, 32'h77,       8, 15,  1, 0, 1, 8, 32'h88,       0);
        tbl[17] = mk(0, 0, 0,  32'h0,        0, 32'h0,        8, 15,  0, 0, 1, 9, 32'h77,       0);
        tbl[18] = mk(0, 0, 0,  32'h0,        0, 32'h0,        2, 15,  1, 0, 1, 2, 32'h99,       0);
        tbl[19] = mk(0, 0, 0,  32'h0,        0, 32'h0,        2, 15,  0, 0, 0, 2, 32'h99,       0);

        // reset state
        #3;
        check("rst.wb_en", {31'd0, wb_en}, 32'd0);
        check("rst.idx",   {28'd0, regIndexWr}, 32'd0);
        check("rst.fw",    regFw, 32'd0);
        check("rst.err",   {31'd0, err}, 32'd0);
        check("rst.full",  {31'd0, full}, 32'd0);
        check("rst.stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // fill with DEPTH loads, overflow push is lost and flags err
        for (int i = 0; i < 4; i++) begin
            run_vec(mk(1, 1, 4'(10 + i), 32'h0, 0, 32'h0, 15, 15,
                       0, 0, 0, 2, 32'h99, 0), $sformatf("fill%0d", i));
        end
        run_vec(mk(1, 0, 14, 32'hEE, 0, 32'h0, 15, 15, 0, 1, 0, 2, 32'h99,   1), "ovf");
        run_vec(mk(0, 0, 0,  32'h0,  1, 32'hA0, 14, 15, 0, 1, 0, 2,  32'h99, 1), "rsp0");
        run_vec(mk(0, 0, 0,  32'h0,  1, 32'hA1, 14, 15, 0, 1, 1, 10, 32'hA0, 1), "rsp1");
        run_vec(mk(0, 0, 0,  32'h0,  1, 32'hA2, 14, 15, 0, 0, 1, 11, 32'hA1, 1), "rsp2");
        run_vec(mk(0, 0, 0,  32'h0,  1, 32'hA3, 14, 15, 0, 0, 1, 12, 32'hA2, 1), "rsp3");
        run_vec(mk(0, 0, 0,  32'h0,  0, 32'h0,  14, 15, 0, 0, 1, 13, 32'hA3, 1), "drain0");
        run_vec(mk(0, 0, 0,  32'h0,  0, 32'h0,  14, 15, 0, 0, 0, 13, 32'hA3, 1), "drain1");

        // back-to-back ALU pushes: one retirement per cycle, pointers wrap
        for (int i = 0; i < 8; i++) begin
            if (i == 0)
                run_vec(mk(1, 0, 4'(i), 32'h100 + i, 0, 32'h0, 15, 15,
                           0, 0, 0, 13, 32'hA3, 1), "b2b0");
            else
                run_vec(mk(1, 0, 4'(i), 32'h100 + i, 0, 32'h0, 15, 15,
                           0, 0, 1, 4'(i - 1), 32'h100 + i - 1, 1), $sformatf("b2b%0d", i));
        end
        run_vec(mk(0, 0, 0, 32'h0, 0, 32'h0, 15, 15, 0, 0, 1, 7, 32'h107, 1), "b2b_tail");
        run_vec(mk(0, 0, 0, 32'h0, 0, 32'h0, 15, 15, 0, 0, 0, 7, 32'h107, 1), "b2b_idle");

        // three entries in flight, then asynchronous reset mid-cycle
        run_vec(mk(1, 1, 1, 32'h0,   0, 32'h0, 15, 15, 0, 0, 0, 7, 32'h107, 1), "pre0");
        run_vec(mk(1, 0, 2, 32'h202, 0, 32'h0, 15, 15, 0, 0, 0, 7, 32'h107, 1), "pre1");
        run_vec(mk(1, 0, 3, 32'h303, 0, 32'h0, 15, 15, 0, 0, 0, 7, 32'h107, 1), "pre2");
        @(negedge clk);
        ex_valid = 1'b0;
        rs0      = 4'd2;
        #2;
        rst_n    = 1'b0;
        #1;
        check("arst.wb_en", {31'd0, wb_en}, 32'd0);
        check("arst.idx",   {28'd0, regIndexWr}, 32'd0);
        check("arst.fw",    regFw, 32'd0);
        check("arst.err",   {31'd0, err}, 32'd0);
        check("arst.stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(0, 0, 0, 32'h0,  0, 32'h0,  2, 15, 0, 0, 0, 0, 32'h0,  0), "post0");
        run_vec(mk(0, 0, 0, 32'h0,  0, 32'h0,  2, 15, 0, 0, 0, 0, 32'h0,  0), "post1");
        // response with no pending load: err only, bus and queue untouched
        run_vec(mk(0, 0, 0, 32'h0,  1, 32'hCC, 15, 15, 0, 0, 0, 0, 32'h0,  1), "orphan");
        run_vec(mk(1, 0, 4, 32'h55, 0, 32'h0,  15, 15, 0, 0, 0, 0, 32'h0,  1), "after0");
        run_vec(mk(0, 0, 0, 32'h0,  0, 32'h0,   4, 15, 1, 0, 1, 4, 32'h55, 1), "after1");
        run_vec(mk(0, 0, 0, 32'h0,  0, 32'h0,   4, 15, 0, 0, 0, 4, 32'h55, 1), "after2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
